// File: rtl/pong_pkg.sv
// Shared definitions for the pong game: game state codes, player input codes
// and the tick sequencer's own states.
package pong_pkg;

  typedef enum logic [2:0] {
    INIT       = 3'b001,
    INIT_POINT = 3'b010,
    RUN_POINT  = 3'b011,
    POINT_OVER = 3'b101,
    GAME_OVER  = 3'b110
  } game_state_e;

  typedef enum logic [1:0] {
    SEQ_IDLE,
    SEQ_RUN,
    SEQ_HOLD
  } seq_state_e;

  localparam logic [1:0] UP   = 2'b10;
  localparam logic [1:0] DOWN = 2'b01;
  localparam logic [1:0] NONE = 2'b00;

  // Both buttons pressed at once cancel out to no input.
  function automatic logic [1:0] button_code(input logic [1:0] b);
    return (b == UP || b == DOWN) ? b : NONE;
  endfunction

endpackage

// File: rtl/pong_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a one-clk pulse whenever
// the synchronised level changes; the caller qualifies direction with level.
module pong_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic toggle
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= d;
      level <= meta;
      prev  <= level;
    end
  end

  assign toggle = level ^ prev;

endmodule

// File: rtl/game_tick_sequencer.sv
// Turns VGA vsync into one game_step per frame, holds a serve pause after each
// point, debounces the start button and frame-samples both players' buttons.
module game_tick_sequencer
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES    = 3,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter bit          VSYNC_ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        start_btn,
  input  logic [1:0]  btn_left,
  input  logic [1:0]  btn_right,
  input  logic [2:0]  game_state,
  output logic        game_step,
  output logic        start_game,
  output logic [1:0]  player_left_input,
  output logic [1:0]  player_right_input,
  output logic        serve_hold,
  output logic [15:0] frame_count
);

  localparam int unsigned DW = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES + 1);
  localparam int unsigned HW = (SERVE_DELAY_FRAMES < 2) ? 1 : $clog2(SERVE_DELAY_FRAMES + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_FRAMES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(SERVE_DELAY_FRAMES);

  logic vsync_level, vsync_toggle;
  logic start_level, start_toggle;
  logic frame_tick, start_release;
  logic [1:0] left_meta, left_sync, right_meta, right_sync;

  seq_state_e     state;
  logic [HW-1:0]  hold_cnt;
  logic [DW-1:0]  deb_cnt;

  pong_sync_edge u_vsync_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (vsync),
    .level  (vsync_level),
    .toggle (vsync_toggle)
  );

  pong_sync_edge u_start_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (start_btn),
    .level  (start_level),
    .toggle (start_toggle)
  );

  assign frame_tick    = vsync_toggle && (vsync_level != VSYNC_ACTIVE_LOW);
  assign start_release = start_toggle && !start_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      left_meta  <= '0;
      left_sync  <= '0;
      right_meta <= '0;
      right_sync <= '0;
    end else begin
      left_meta  <= btn_left;
      left_sync  <= left_meta;
      right_meta <= btn_right;
      right_sync <= right_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count        <= '0;
      player_left_input  <= '0;
      player_right_input <= '0;
    end else if (frame_tick) begin
      frame_count        <= frame_count + 1'b1;
      player_left_input  <= button_code(left_sync);
      player_right_input <= button_code(right_sync);
    end
  end

  // Saturating count means a held button fires once; a pulse missed outside
  // IDLE is not remembered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt    <= '0;
      start_game <= 1'b0;
    end else begin
      start_game <= 1'b0;
      if (start_release) begin
        deb_cnt <= '0;
      end else if (frame_tick) begin
        if (!start_level) begin
          deb_cnt <= '0;
        end else if (deb_cnt != DEB_MAX) begin
          deb_cnt <= deb_cnt + 1'b1;
          if (deb_cnt == DEB_LAST && state == SEQ_IDLE) start_game <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEQ_IDLE;
      hold_cnt   <= '0;
      game_step  <= 1'b0;
      serve_hold <= 1'b0;
    end else begin
      game_step <= 1'b0;
      unique case (state)
        SEQ_IDLE: begin
          if (game_state == INIT_POINT) state <= SEQ_RUN;
        end
        SEQ_RUN: begin
          game_step <= frame_tick;
          if (game_state == POINT_OVER) begin
            state      <= SEQ_HOLD;
            hold_cnt   <= HOLD_LOAD;
            serve_hold <= 1'b1;
          end else if (game_state == GAME_OVER || game_state == INIT) begin
            state <= SEQ_IDLE;
          end
        end
        SEQ_HOLD: begin
          if (game_state == GAME_OVER) begin
            state      <= SEQ_IDLE;
            hold_cnt   <= '0;
            serve_hold <= 1'b0;
          end else if (hold_cnt == '0) begin
            // Zero-length pause: pass a coinciding tick through so no frame is lost.
            state      <= SEQ_RUN;
            serve_hold <= 1'b0;
            game_step  <= frame_tick;
          end else if (frame_tick) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) begin
              state      <= SEQ_RUN;
              serve_hold <= 1'b0;
            end
          end
        end
        default: state <= SEQ_IDLE;
      endcase
    end
  end

endmodule
